// File: rtl/plic_claim_master.sv
// PLIC target-side claim/complete engine: reads the context claim register over AXI4,
// presents the claimed source ID to a local consumer, and writes it back on completion.
module plic_claim_master #(
  parameter int          LOCAL_DATA_WIDTH = 32,
  parameter int          LOCAL_ADDR_WIDTH = 32,
  parameter int          LOCAL_ID_WIDTH   = 2,
  parameter logic [31:0] PLIC_BASE_ADDR   = 32'h0400_0000,
  parameter int          CONTEXT          = 0
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          irq_i,
  input  logic                          enable_i,
  output logic                          claim_valid_o,
  output logic [9:0]                    claim_id_o,
  input  logic                          complete_i,
  output logic                          busy_o,
  output logic                          err_o,

  output logic [LOCAL_ID_WIDTH-1:0]     m_axi_awid,
  output logic [LOCAL_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]                    m_axi_awlen,
  output logic [2:0]                    m_axi_awsize,
  output logic [1:0]                    m_axi_awburst,
  output logic                          m_axi_awlock,
  output logic [3:0]                    m_axi_awcache,
  output logic [2:0]                    m_axi_awprot,
  output logic [3:0]                    m_axi_awqos,
  output logic [3:0]                    m_axi_awregion,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,

  output logic [LOCAL_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [LOCAL_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                          m_axi_wlast,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,

  input  logic [LOCAL_ID_WIDTH-1:0]     m_axi_bid,
  input  logic [1:0]                    m_axi_bresp,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready,

  output logic [LOCAL_ID_WIDTH-1:0]     m_axi_arid,
  output logic [LOCAL_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]                    m_axi_arlen,
  output logic [2:0]                    m_axi_arsize,
  output logic [1:0]                    m_axi_arburst,
  output logic                          m_axi_arlock,
  output logic [3:0]                    m_axi_arcache,
  output logic [2:0]                    m_axi_arprot,
  output logic [3:0]                    m_axi_arqos,
  output logic [3:0]                    m_axi_arregion,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,

  input  logic [LOCAL_ID_WIDTH-1:0]     m_axi_rid,
  input  logic [LOCAL_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rlast,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready
);

  // state | meaning
  // IDLE  | waiting for irq_i && enable_i
  // AR    | claim read address presented
  // R     | waiting for claim read data
  // HOLD  | claimed ID presented to consumer
  // WR    | complete write address/data in flight
  // B     | waiting for write response

  localparam int STRB_W = LOCAL_DATA_WIDTH / 8;
  localparam logic [63:0] ADDR_FULL = {32'b0, PLIC_BASE_ADDR} + 64'h0000_0000_0020_0004
                                      + (64'(CONTEXT) << 12);
  localparam logic [LOCAL_ADDR_WIDTH-1:0] CLAIM_ADDR = ADDR_FULL[LOCAL_ADDR_WIDTH-1:0];
  localparam bit HI_LANE  = (LOCAL_DATA_WIDTH == 64) && ADDR_FULL[2];
  localparam int LANE_LSB = HI_LANE ? 32 : 0;
  localparam logic [STRB_W-1:0] WSTRB = (LOCAL_DATA_WIDTH == 64) ?
                                        (HI_LANE ? STRB_W'(8'hF0) : STRB_W'(8'h0F)) :
                                        STRB_W'(4'hF);

  typedef enum logic [2:0] {
    S_IDLE, S_AR, S_R, S_HOLD, S_WR, S_B
  } state_t;

  state_t     state;
  logic       aw_done;
  logic       w_done;
  logic       aw_fin;
  logic       w_fin;
  logic [9:0] rd_id;

  assign m_axi_awid     = '0;
  assign m_axi_awaddr   = CLAIM_ADDR;
  assign m_axi_awlen    = 8'd0;
  assign m_axi_awsize   = 3'b010;
  assign m_axi_awburst  = 2'b01;
  assign m_axi_awlock   = 1'b0;
  assign m_axi_awcache  = 4'd0;
  assign m_axi_awprot   = 3'd0;
  assign m_axi_awqos    = 4'd0;
  assign m_axi_awregion = 4'd0;
  assign m_axi_arid     = '0;
  assign m_axi_araddr   = CLAIM_ADDR;
  assign m_axi_arlen    = 8'd0;
  assign m_axi_arsize   = 3'b010;
  assign m_axi_arburst  = 2'b01;
  assign m_axi_arlock   = 1'b0;
  assign m_axi_arcache  = 4'd0;
  assign m_axi_arprot   = 3'd0;
  assign m_axi_arqos    = 4'd0;
  assign m_axi_arregion = 4'd0;
  assign m_axi_wlast    = 1'b1;
  assign m_axi_wstrb    = WSTRB;

  // The ID is replicated into every 32-bit lane; wstrb selects the lane the PLIC decodes.
  assign m_axi_wdata = {(LOCAL_DATA_WIDTH/32){22'b0, claim_id_o}};
  assign rd_id       = m_axi_rdata[LANE_LSB +: 10];

  assign aw_fin = aw_done | (m_axi_awvalid & m_axi_awready);
  assign w_fin  = w_done  | (m_axi_wvalid  & m_axi_wready);

  // Single-beat reads and writes make these fields irrelevant.
  logic unused_axi;
  assign unused_axi = ^{m_axi_rid, m_axi_rlast, m_axi_bid, m_axi_rdata};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= S_IDLE;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      claim_valid_o <= 1'b0;
      claim_id_o    <= 10'd0;
      busy_o        <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      err_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (irq_i && enable_i) begin
            m_axi_arvalid <= 1'b1;
            busy_o        <= 1'b1;
            state         <= S_AR;
          end
        end
        S_AR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= S_R;
          end
        end
        S_R: begin
          if (m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            if (m_axi_rresp != 2'b00) begin
              err_o  <= 1'b1;
              busy_o <= 1'b0;
              state  <= S_IDLE;
            end else if (rd_id == 10'd0) begin
              busy_o <= 1'b0;
              state  <= S_IDLE;
            end else begin
              claim_id_o    <= rd_id;
              claim_valid_o <= 1'b1;
              state         <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (complete_i) begin
            claim_valid_o <= 1'b0;
            m_axi_awvalid <= 1'b1;
            m_axi_wvalid  <= 1'b1;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            state         <= S_WR;
          end
        end
        S_WR: begin
          if (m_axi_awvalid && m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wvalid && m_axi_wready)   m_axi_wvalid  <= 1'b0;
          aw_done <= aw_fin;
          w_done  <= w_fin;
          if (aw_fin && w_fin) begin
            m_axi_bready <= 1'b1;
            state        <= S_B;
          end
        end
        S_B: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            err_o        <= (m_axi_bresp != 2'b00);
            busy_o       <= 1'b0;
            state        <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_plic_claim_master.sv
// Scoreboard bench for plic_claim_master: a 32-bit/context-0 instance and a
// 64-bit/context-1 instance, each with a reactive AXI slave.
module tb_plic_claim_master;

  localparam logic [2:0] K_AR = 3'd0, K_CLAIM = 3'd1, K_AW = 3'd2, K_W = 3'd3, K_ERR = 3'd4, K_B = 3'd5;
  typedef struct packed { logic [2:0] kind; logic [79:0] val; } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int   tests = 0;
  int   failed = 0;
  exp_t qa[$];
  exp_t qb[$];

  logic [63:0] k_rdata;
  logic [1:0]  k_rresp, k_bresp;
  int          k_aw_wait, k_w_wait;
  logic        enable, a_irq, b_irq, a_complete, b_complete;

  logic        a_claim_valid, a_busy, a_err;
  logic [9:0]  a_claim_id;
  logic [1:0]  a_awid, a_arid, a_bid, a_rid, a_awburst, a_arburst, a_bresp, a_rresp;
  logic [31:0] a_awaddr, a_araddr, a_wdata, a_rdata;
  logic [7:0]  a_awlen, a_arlen;
  logic [2:0]  a_awsize, a_arsize, a_awprot, a_arprot;
  logic [3:0]  a_awcache, a_arcache, a_awqos, a_arqos, a_awregion, a_arregion, a_wstrb;
  logic        a_awlock, a_arlock, a_awvalid, a_awready, a_wlast, a_wvalid, a_wready;
  logic        a_bvalid, a_bready, a_arvalid, a_arready, a_rlast, a_rvalid, a_rready;

  logic        b_claim_valid, b_busy, b_err;
  logic [9:0]  b_claim_id;
  logic [1:0]  b_awid, b_arid, b_bid, b_rid, b_awburst, b_arburst, b_bresp, b_rresp;
  logic [31:0] b_awaddr, b_araddr;
  logic [63:0] b_wdata, b_rdata;
  logic [7:0]  b_awlen, b_arlen, b_wstrb;
  logic [2:0]  b_awsize, b_arsize, b_awprot, b_arprot;
  logic [3:0]  b_awcache, b_arcache, b_awqos, b_arqos, b_awregion, b_arregion;
  logic        b_awlock, b_arlock, b_awvalid, b_awready, b_wlast, b_wvalid, b_wready;
  logic        b_bvalid, b_bready, b_arvalid, b_arready, b_rlast, b_rvalid, b_rready;

  plic_claim_master dut_a (
    .clk_i(clk), .rst_i(rst), .irq_i(a_irq), .enable_i(enable),
    .claim_valid_o(a_claim_valid), .claim_id_o(a_claim_id), .complete_i(a_complete),
    .busy_o(a_busy), .err_o(a_err),
    .m_axi_awid(a_awid), .m_axi_awaddr(a_awaddr), .m_axi_awlen(a_awlen), .m_axi_awsize(a_awsize),
    .m_axi_awburst(a_awburst), .m_axi_awlock(a_awlock), .m_axi_awcache(a_awcache),
    .m_axi_awprot(a_awprot), .m_axi_awqos(a_awqos), .m_axi_awregion(a_awregion),
    .m_axi_awvalid(a_awvalid), .m_axi_awready(a_awready),
    .m_axi_wdata(a_wdata), .m_axi_wstrb(a_wstrb), .m_axi_wlast(a_wlast),
    .m_axi_wvalid(a_wvalid), .m_axi_wready(a_wready),
    .m_axi_bid(a_bid), .m_axi_bresp(a_bresp), .m_axi_bvalid(a_bvalid), .m_axi_bready(a_bready),
    .m_axi_arid(a_arid), .m_axi_araddr(a_araddr), .m_axi_arlen(a_arlen), .m_axi_arsize(a_arsize),
    .m_axi_arburst(a_arburst), .m_axi_arlock(a_arlock), .m_axi_arcache(a_arcache),
    .m_axi_arprot(a_arprot), .m_axi_arqos(a_arqos), .m_axi_arregion(a_arregion),
    .m_axi_arvalid(a_arvalid), .m_axi_arready(a_arready),
    .m_axi_rid(a_rid), .m_axi_rdata(a_rdata), .m_axi_rresp(a_rresp), .m_axi_rlast(a_rlast),
    .m_axi_rvalid(a_rvalid), .m_axi_rready(a_rready)
  );

  plic_claim_master #(.LOCAL_DATA_WIDTH(64), .CONTEXT(1)) dut_b (
    .clk_i(clk), .rst_i(rst), .irq_i(b_irq), .enable_i(enable),
    .claim_valid_o(b_claim_valid), .claim_id_o(b_claim_id), .complete_i(b_complete),
    .busy_o(b_busy), .err_o(b_err),
    .m_axi_awid(b_awid), .m_axi_awaddr(b_awaddr), .m_axi_awlen(b_awlen), .m_axi_awsize(b_awsize),
    .m_axi_awburst(b_awburst), .m_axi_awlock(b_awlock), .m_axi_awcache(b_awcache),
    .m_axi_awprot(b_awprot), .m_axi_awqos(b_awqos), .m_axi_awregion(b_awregion),
    .m_axi_awvalid(b_awvalid), .m_axi_awready(b_awready),
    .m_axi_wdata(b_wdata), .m_axi_wstrb(b_wstrb), .m_axi_wlast(b_wlast),
    .m_axi_wvalid(b_wvalid), .m_axi_wready(b_wready),
    .m_axi_bid(b_bid), .m_axi_bresp(b_bresp), .m_axi_bvalid(b_bvalid), .m_axi_bready(b_bready),
    .m_axi_arid(b_arid), .m_axi_araddr(b_araddr), .m_axi_arlen(b_arlen), .m_axi_arsize(b_arsize),
    .m_axi_arburst(b_arburst), .m_axi_arlock(b_arlock), .m_axi_arcache(b_arcache),
    .m_axi_arprot(b_arprot), .m_axi_arqos(b_arqos), .m_axi_arregion(b_arregion),
    .m_axi_arvalid(b_arvalid), .m_axi_arready(b_arready),
    .m_axi_rid(b_rid), .m_axi_rdata(b_rdata), .m_axi_rresp(b_rresp), .m_axi_rlast(b_rlast),
    .m_axi_rvalid(b_rvalid), .m_axi_rready(b_rready)
  );

  function automatic string kname(input logic [2:0] k);
    case (k)
      K_AR:    return "ar";
      K_CLAIM: return "claim";
      K_AW:    return "aw";
      K_W:     return "w";
      K_ERR:   return "err";
      default: return "b";
    endcase
  endfunction

  function automatic void chk(input string nm, input logic [82:0] act, input logic [82:0] req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s: actual %h required %h", nm, act, req);
    end
  endfunction

  function automatic void push(input bit dut_b, input logic [2:0] k, input logic [79:0] v);
    if (dut_b) qb.push_back({k, v});
    else       qa.push_back({k, v});
  endfunction

  function automatic void obs(input bit dut_b, input logic [2:0] k, input logic [79:0] v);
    exp_t  e;
    string nm;
    nm = $sformatf("%s_%s", dut_b ? "b" : "a", kname(k));
    if ((dut_b && qb.size() == 0) || (!dut_b && qa.size() == 0)) begin
      tests++;
      failed++;
      $display("FAIL %s: unexpected event actual %h required none", nm, v);
    end else begin
      if (dut_b) e = qb.pop_front();
      else       e = qa.pop_front();
      chk(nm, {k, v}, {e.kind, e.val});
    end
  endfunction

  // Monitor: every observed handshake/event is checked against the head of its queue.
  initial begin
    logic a_cv_prev, b_cv_prev;
    a_cv_prev = 1'b0;
    b_cv_prev = 1'b0;
    forever begin
      @(negedge clk); #1;
      if (!rst) begin
        if (a_arvalid && a_arready)      obs(1'b0, K_AR, 80'({a_arsize, a_araddr}));
        if (a_claim_valid && !a_cv_prev) obs(1'b0, K_CLAIM, 80'(a_claim_id));
        if (a_awvalid && a_awready)      obs(1'b0, K_AW, 80'(a_awaddr));
        if (a_wvalid && a_wready)        obs(1'b0, K_W, 80'({a_wstrb, a_wdata}));
        if (a_err)                       obs(1'b0, K_ERR, 80'd0);
        if (a_bvalid && a_bready)        obs(1'b0, K_B, 80'(a_bresp));
        if (b_arvalid && b_arready)      obs(1'b1, K_AR, 80'({b_arsize, b_araddr}));
        if (b_claim_valid && !b_cv_prev) obs(1'b1, K_CLAIM, 80'(b_claim_id));
        if (b_awvalid && b_awready)      obs(1'b1, K_AW, 80'(b_awaddr));
        if (b_wvalid && b_wready)        obs(1'b1, K_W, 80'({b_wstrb, b_wdata}));
        if (b_err)                       obs(1'b1, K_ERR, 80'd0);
        if (b_bvalid && b_bready)        obs(1'b1, K_B, 80'(b_bresp));
      end
      a_cv_prev = a_claim_valid;
      b_cv_prev = b_claim_valid;
    end
  end

  // Reactive slave for the 32-bit instance.
  initial begin
    int aw_cnt, w_cnt;
    aw_cnt = 0; w_cnt = 0;
    a_arready = 1'b0; a_rvalid = 1'b0; a_rdata = '0; a_rresp = 2'b00; a_rid = '0; a_rlast = 1'b1;
    a_awready = 1'b0; a_wready = 1'b0; a_bvalid = 1'b0; a_bresp = 2'b00; a_bid = '0;
    forever begin
      @(negedge clk);
      if (a_arready) a_arready = 1'b0;
      else if (a_arvalid) a_arready = 1'b1;
      if (a_rvalid) a_rvalid = 1'b0;
      else if (a_rready) begin a_rvalid = 1'b1; a_rdata = k_rdata[31:0]; a_rresp = k_rresp; end
      if (a_awready) a_awready = 1'b0;
      else if (a_awvalid) begin
        if (aw_cnt < k_aw_wait) aw_cnt++;
        else begin a_awready = 1'b1; aw_cnt = 0; end
      end
      if (a_wready) a_wready = 1'b0;
      else if (a_wvalid) begin
        if (w_cnt < k_w_wait) w_cnt++;
        else begin a_wready = 1'b1; w_cnt = 0; end
      end
      if (a_bvalid) a_bvalid = 1'b0;
      else if (a_bready) begin a_bvalid = 1'b1; a_bresp = k_bresp; end
    end
  end

  // Reactive slave for the 64-bit instance (zero-wait).
  initial begin
    b_arready = 1'b0; b_rvalid = 1'b0; b_rdata = '0; b_rresp = 2'b00; b_rid = '0; b_rlast = 1'b1;
    b_awready = 1'b0; b_wready = 1'b0; b_bvalid = 1'b0; b_bresp = 2'b00; b_bid = '0;
    forever begin
      @(negedge clk);
      if (b_arready) b_arready = 1'b0;
      else if (b_arvalid) b_arready = 1'b1;
      if (b_rvalid) b_rvalid = 1'b0;
      else if (b_rready) begin b_rvalid = 1'b1; b_rdata = k_rdata; b_rresp = k_rresp; end
      if (b_awready) b_awready = 1'b0;
      else if (b_awvalid) b_awready = 1'b1;
      if (b_wready) b_wready = 1'b0;
      else if (b_wvalid) b_wready = 1'b1;
      if (b_bvalid) b_bvalid = 1'b0;
      else if (b_bready) begin b_bvalid = 1'b1; b_bresp = k_bresp; end
    end
  end

  task automatic step();
    @(negedge clk); #2;
  endtask

  task automatic wait_claim(input bit dut_b);
    for (int i = 0; i < 100; i++) begin
      step();
      if ((dut_b ? b_claim_valid : a_claim_valid) == 1'b1) break;
    end
    if (dut_b) chk("b_claim_wait", 83'(b_claim_valid), 83'd1);
    else       chk("a_claim_wait", 83'(a_claim_valid), 83'd1);
  endtask

  task automatic wait_idle(input bit dut_b);
    for (int i = 0; i < 100; i++) begin
      step();
      if ((dut_b ? b_busy : a_busy) == 1'b0) break;
    end
    if (dut_b) chk("b_idle_wait", 83'(b_busy), 83'd0);
    else       chk("a_idle_wait", 83'(a_busy), 83'd0);
  endtask

  task automatic pulse_complete(input bit dut_b);
    if (dut_b) b_complete = 1'b1;
    else       a_complete = 1'b1;
    step();
    a_complete = 1'b0;
    b_complete = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual no finish required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] wr_exp [5];
    wr_exp = '{3'b110, 3'b100, 3'b100, 3'b100, 3'b001};
    rst = 1'b1; enable = 1'b1; a_irq = 1'b0; b_irq = 1'b0; a_complete = 1'b0; b_complete = 1'b0;
    k_rdata = '0; k_rresp = 2'b00; k_bresp = 2'b00; k_aw_wait = 0; k_w_wait = 0;
    repeat (3) step();
    chk("a_reset_outs", 83'({a_arvalid, a_rready, a_awvalid, a_wvalid, a_bready,
                             a_claim_valid, a_busy, a_err, a_claim_id}), 83'd0);
    chk("b_reset_outs", 83'({b_arvalid, b_rready, b_awvalid, b_wvalid, b_bready,
                             b_claim_valid, b_busy, b_err, b_claim_id}), 83'd0);
    chk("a_aw_const", 83'({a_awid, a_awlen, a_awsize, a_awburst, a_awlock, a_awcache, a_awprot,
                           a_awqos, a_awregion, a_wlast}),
        83'({2'b0, 8'd0, 3'b010, 2'b01, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0, 1'b1}));
    chk("a_ar_const", 83'({a_arid, a_arlen, a_arsize, a_arburst, a_arlock, a_arcache, a_arprot,
                           a_arqos, a_arregion}),
        83'({2'b0, 8'd0, 3'b010, 2'b01, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0}));
    chk("b_aw_const", 83'({b_awid, b_awlen, b_awsize, b_awburst, b_awlock, b_awcache, b_awprot,
                           b_awqos, b_awregion, b_wlast}),
        83'({2'b0, 8'd0, 3'b010, 2'b01, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0, 1'b1}));
    chk("b_ar_const", 83'({b_arid, b_arlen, b_arsize, b_arburst, b_arlock, b_arcache, b_arprot,
                           b_arqos, b_arregion}),
        83'({2'b0, 8'd0, 3'b010, 2'b01, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0}));
    rst = 1'b0;
    step();

    // enable_i low blocks claims; complete_i in IDLE is ignored
    enable = 1'b0; a_irq = 1'b1;
    repeat (3) step();
    chk("a_enable_gate", 83'(a_busy), 83'd0);
    a_irq = 1'b0; enable = 1'b1;
    step();
    pulse_complete(1'b0);
    step();
    chk("a_complete_idle", 83'({a_busy, a_awvalid, a_wvalid}), 83'd0);

    // basic claim of ID 5 and completion
    k_rdata = 64'd5;
    push(1'b0, K_AR, 80'({3'b010, 32'h0420_0004}));
    push(1'b0, K_CLAIM, 80'd5);
    push(1'b0, K_AW, 80'(32'h0420_0004));
    push(1'b0, K_W, 80'({4'hF, 32'd5}));
    push(1'b0, K_B, 80'd0);
    a_irq = 1'b1;
    wait_claim(1'b0);
    a_irq = 1'b0;
    repeat (3) step();
    chk("a_hold_stable", 83'({a_claim_valid, a_busy, a_claim_id}), 83'({1'b1, 1'b1, 10'd5}));
    pulse_complete(1'b0);
    wait_idle(1'b0);
    step();
    chk("a_t1_pending", 83'(qa.size()), 83'd0);

    // spurious ID 0: no claim, no write
    k_rdata = 64'd0;
    push(1'b0, K_AR, 80'({3'b010, 32'h0420_0004}));
    a_irq = 1'b1; step(); a_irq = 1'b0;
    wait_idle(1'b0);
    repeat (3) step();
    chk("a_spurious_pending", 83'(qa.size()), 83'd0);

    // read SLVERR: single err pulse, no write
    k_rdata = 64'd9; k_rresp = 2'b10;
    push(1'b0, K_AR, 80'({3'b010, 32'h0420_0004}));
    push(1'b0, K_ERR, 80'd0);
    a_irq = 1'b1; step(); a_irq = 1'b0;
    wait_idle(1'b0);
    repeat (3) step();
    chk("a_slverr_pending", 83'(qa.size()), 83'd0);
    k_rresp = 2'b00;

    // awready stalled 3 cycles; irq held so a re-claim follows one IDLE cycle
    k_rdata = 64'hABCD_F6A5; k_aw_wait = 3;
    push(1'b0, K_AR, 80'({3'b010, 32'h0420_0004}));
    push(1'b0, K_CLAIM, 80'h2A5);
    push(1'b0, K_W, 80'({4'hF, 32'h0000_02A5}));
    push(1'b0, K_AW, 80'(32'h0420_0004));
    push(1'b0, K_B, 80'd0);
    push(1'b0, K_AR, 80'({3'b010, 32'h0420_0004}));
    a_irq = 1'b1;
    wait_claim(1'b0);
    k_rdata = 64'd0;
    chk("a_claim_id_mask", 83'(a_claim_id), 83'h2A5);
    a_complete = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      a_complete = 1'b0;
      chk($sformatf("a_wr_cycle%0d", i), 83'({a_awvalid, a_wvalid, a_bready}), 83'(wr_exp[i]));
    end
    step();
    chk("a_idle_gap", 83'({a_busy, a_arvalid, a_awvalid, a_wvalid, a_bready}), 83'd0);
    step();
    chk("a_reclaim", 83'(a_arvalid), 83'd1);
    a_irq = 1'b0;
    wait_idle(1'b0);
    repeat (2) step();
    chk("a_stall_pending", 83'(qa.size()), 83'd0);
    k_aw_wait = 0;

    // async reset while rvalid pending, then restart; write response SLVERR
    k_rdata = 64'd4;
    push(1'b0, K_AR, 80'({3'b010, 32'h0420_0004}));
    a_irq = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (a_rvalid) break;
      step();
    end
    chk("a_rvalid_pending", 83'({a_rvalid, a_rready}), 83'b11);
    rst = 1'b1;
    #1;
    chk("a_async_reset", 83'({a_arvalid, a_rready, a_awvalid, a_wvalid, a_bready,
                              a_claim_valid, a_busy, a_err, a_claim_id}), 83'd0);
    k_bresp = 2'b10;
    push(1'b0, K_AR, 80'({3'b010, 32'h0420_0004}));
    push(1'b0, K_CLAIM, 80'd4);
    push(1'b0, K_AW, 80'(32'h0420_0004));
    push(1'b0, K_W, 80'({4'hF, 32'd4}));
    push(1'b0, K_B, 80'd2);
    push(1'b0, K_ERR, 80'd0);
    step();
    rst = 1'b0;
    wait_claim(1'b0);
    a_irq = 1'b0;
    pulse_complete(1'b0);
    wait_idle(1'b0);
    repeat (2) step();
    chk("a_restart_pending", 83'(qa.size()), 83'd0);
    k_bresp = 2'b00;

    // 64-bit bus, context 1: upper lane
    k_rdata = 64'h0000_0007_0000_0003;
    push(1'b1, K_AR, 80'({3'b010, 32'h0420_1004}));
    push(1'b1, K_CLAIM, 80'd7);
    push(1'b1, K_AW, 80'(32'h0420_1004));
    push(1'b1, K_W, 80'({8'hF0, 64'h0000_0007_0000_0007}));
    push(1'b1, K_B, 80'd0);
    b_irq = 1'b1;
    wait_claim(1'b1);
    b_irq = 1'b0;
    chk("b_claim_id", 83'(b_claim_id), 83'd7);
    pulse_complete(1'b1);
    wait_idle(1'b1);
    repeat (2) step();
    chk("b_pending", 83'(qb.size()), 83'd0);
    chk("a_final_pending", 83'(qa.size()), 83'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
